// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow screen sequencer.
package game_pkg;

  // Screen states; the encoding is visible on the debug `screen` output.
  typedef enum logic [1:0] {
    TITLE     = 2'd0,
    PLAY      = 2'd1,
    LEVEL_UP  = 2'd2,
    GAME_OVER = 2'd3
  } screen_state_e;

  localparam logic [7:0] RGB_BLACK = 8'h00;

  // Larger of two integers, used to size the shared frame counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Saturating frame counter shared by the timed screens (level-up banner and
// game-over key lock). Clear wins over a tick; the count stops at limit_i so
// it can never wrap.
module frame_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_limit_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear, saturating increment on tick, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (tick_i && (count_q != limit_i)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q == limit_i);

endmodule

// File: rtl/screens_sequencer.sv
// Game-flow controller: walks title -> play -> (level-up banner) -> game-over,
// generates the new-game start pulse and the main-screen pause request, and
// selects which screen's pixel reaches the VGA output (one cycle of latency).
module screens_sequencer
  import game_pkg::*;
#(
  parameter int LEVEL_FRAMES         = 120,
  parameter int GAMEOVER_LOCK_FRAMES = 60
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       key5IsPressed,
  input  logic [3:0] life,
  input  logic [3:0] level,
  input  logic [7:0] RGB_screen_start,
  input  logic [7:0] RGB_screen_main,
  input  logic [7:0] RGB_screen_level,
  input  logic [7:0] RGB_screen_end,
  output logic [7:0] RGB_out,
  output logic       start,
  output logic       pause,
  output logic [1:0] screen
);

  localparam int CNT_W = $clog2(max_int(LEVEL_FRAMES, GAMEOVER_LOCK_FRAMES) + 1);
  localparam logic [CNT_W-1:0] LVL_LAST = CNT_W'(LEVEL_FRAMES - 1);
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(GAMEOVER_LOCK_FRAMES);

  screen_state_e    state_q, state_d;
  logic             key_prev_q;
  logic [3:0]       level_prev_q, level_prev_d;
  logic [7:0]       rgb_q, rgb_d;
  logic             start_q, start_d;
  logic             pause_q, pause_d;

  logic             press;
  logic             timer_clr;
  logic             timer_tick;
  logic [CNT_W-1:0] timer_limit;
  logic [CNT_W-1:0] timer_count;
  logic             timer_at_limit;

  // Rising edge of the key; key_prev resets high so a key held through reset
  // does not count as a press.
  assign press = key5IsPressed & ~key_prev_q;

  // The counter only advances in the two timed screens; its saturation point
  // depends on which one is active.
  assign timer_tick  = startOfFrame &&
                       ((state_q == LEVEL_UP) || (state_q == GAME_OVER));
  assign timer_limit = (state_q == LEVEL_UP) ? LVL_LAST : LOCK_LIM;

  frame_timer #(
    .CNT_W (CNT_W)
  ) u_frame_timer (
    .clk_i      (clk),
    .rst_ni     (resetN),
    .clr_i      (timer_clr),
    .tick_i     (timer_tick),
    .limit_i    (timer_limit),
    .count_o    (timer_count),
    .at_limit_o (timer_at_limit)
  );

  // Next-state, pixel source and registered-output decodes.
  always_comb begin
    state_d      = state_q;
    level_prev_d = level_prev_q;
    rgb_d        = RGB_BLACK;
    timer_clr    = 1'b0;
    unique case (state_q)
      TITLE: begin
        rgb_d = RGB_screen_start;
        if (press) begin
          state_d      = PLAY;
          level_prev_d = '0;
        end
      end
      PLAY: begin
        rgb_d        = RGB_screen_main;
        level_prev_d = level;
        // Game over has priority over a simultaneous level increase.
        if (life == 4'd0) begin
          state_d   = GAME_OVER;
          timer_clr = 1'b1;
        end else if (level > level_prev_q) begin
          state_d   = LEVEL_UP;
          timer_clr = 1'b1;
        end
      end
      LEVEL_UP: begin
        rgb_d = RGB_screen_level;
        if (startOfFrame && timer_at_limit) begin
          state_d = PLAY;
        end
      end
      GAME_OVER: begin
        rgb_d = RGB_screen_end;
        if (press && timer_at_limit) begin
          state_d = TITLE;
        end
      end
      default: state_d = TITLE;
    endcase
    start_d = (state_q == TITLE) && (state_d == PLAY);
    pause_d = (state_d != PLAY);
  end

  // State, history and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= TITLE;
      key_prev_q   <= 1'b1;
      level_prev_q <= '0;
      rgb_q        <= RGB_BLACK;
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_prev_q   <= key5IsPressed;
      level_prev_q <= level_prev_d;
      rgb_q        <= rgb_d;
      start_q      <= start_d;
      pause_q      <= pause_d;
    end
  end

  assign RGB_out = rgb_q;
  assign start   = start_q;
  assign pause   = pause_q;
  assign screen  = state_q;

endmodule

// File: doc/screens_sequencer.md
Name: screens_sequencer

Overview:
Top-level game-flow controller that sequences the displayed screen: title, play, level-up banner, and game-over.
- Owns the one-cycle `start` pulse into the main screen, and the `pause` hold during transitions.
- Selects which screen's 8-bit RGB reaches the VGA output.
- Sits above the main screen: consumes its `life`/`level` status and the RGB streams of all screens.

Parameters:
- LEVEL_FRAMES, 120: frames the level-up banner stays up before play resumes (≥1).
- GAMEOVER_LOCK_FRAMES, 60: frames after entering game-over during which key presses are ignored (≥0).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- key5IsPressed  in  1  level of the start/confirm key
- life  in  4  remaining lives from main screen
- level  in  4  current level from main screen
- RGB_screen_start  in  8  title screen pixel
- RGB_screen_main  in  8  main screen pixel
- RGB_screen_level  in  8  level-up banner pixel (composited by its own block)
- RGB_screen_end  in  8  game-over screen pixel
- RGB_out  out  8  selected pixel, registered
- start  out  1  one-cycle pulse: new game begins
- pause  out  1  main screen freeze request
- screen  out  2  current state encoding (debug/LEDs)

Behaviour:
- Clock and reset: one clock `clk`; reset `resetN` is asynchronous, active-low.
- Reset values: state = TITLE, RGB_out = 0, start = 0, pause = 0, screen = 0, frameCnt = 0, keyPrev = 1 (a key held through reset is not a press), levelPrev = 0.
- Key press definition: press = key5IsPressed & ~keyPrev.
  - keyPrev is registered every cycle.
  - Presses are never queued; a press ignored in one state is lost.
- States and encoding: TITLE = 0, PLAY = 1, LEVEL_UP = 2, GAME_OVER = 3.
- TITLE:
  - RGB source: start screen; pause = 1.
  - On press: go to PLAY, assert start for exactly the cycle after the press cycle, clear levelPrev to 0.
- PLAY:
  - RGB source: main screen; pause = 0; levelPrev <= level every cycle.
  - If life == 0: go to GAME_OVER, clear frameCnt.
  - Else if level > levelPrev (unsigned): go to LEVEL_UP, clear frameCnt.
  - A level decrease or wrap (e.g. 15 → 0) is not a level-up.
  - If life == 0 and a level increase occur in the same cycle, GAME_OVER wins.
  - Presses are ignored in PLAY; pause toggling stays in the main screen's own controller.
- LEVEL_UP:
  - RGB source: level banner; pause = 1.
  - frameCnt increments on each startOfFrame.
  - When frameCnt reaches LEVEL_FRAMES-1 and startOfFrame = 1, return to PLAY (pause drops the next cycle).
  - Presses are ignored.
- GAME_OVER:
  - RGB source: end screen; pause = 1.
  - frameCnt increments on startOfFrame and saturates at GAMEOVER_LOCK_FRAMES.
  - A press is accepted only when frameCnt == GAMEOVER_LOCK_FRAMES; then go to TITLE.
- Frame counter: width is $clog2(max(LEVEL_FRAMES, GAMEOVER_LOCK_FRAMES)+1); it never wraps.
- RGB latency:
  - RGB_out = mux(state) registered, i.e. 1 cycle after the input pixel.
  - On a state change, the new source appears on the cycle after the state register updates.
- start and pause are registered decodes of the next state; no combinational input-to-output paths.
- Reset mid-operation: an asynchronous return to all reset values from any state; a partially counted frameCnt is discarded.

Decomposition:
- Shared package (game_pkg):
  - typedef enum logic [1:0] SCREEN_STATE {TITLE, PLAY, LEVEL_UP, GAME_OVER};
  - RGB_BLACK = 8'h00.
- One natural sub-module: frame_timer (counts startOfFrame, clear/saturate/done outputs), reused by both timed states.
- Key edge detection stays inline.

Test Plan:
1. Reset with key held, release, then press once → state TITLE → PLAY; start high exactly 1 cycle; RGB_out tracks RGB_screen_main one cycle later; pause = 0.
2. In PLAY, level 0 → 1 → state LEVEL_UP, pause = 1, RGB_out = RGB_screen_level. With LEVEL_FRAMES = 3, after the 3rd startOfFrame the state is PLAY and pause = 0.
3. In PLAY, life 1 → 0 in the same cycle as level 2 → 3 → state GAME_OVER (not LEVEL_UP), screen = 3.
4. In GAME_OVER with GAMEOVER_LOCK_FRAMES = 2: press after 1 frame → ignored, stays GAME_OVER; press after 2 frames → TITLE, start stays 0.
5. In PLAY, level 15 → 0 → no LEVEL_UP; key presses in PLAY → no state change, no start pulse.
6. Assert resetN low mid-LEVEL_UP (frameCnt = 1) → immediately TITLE, RGB_out = 0, pause = 0. After release, a new game's level-up runs the full LEVEL_FRAMES.
